popcnt_accum_thresh: RTL and testbench

POPCNT_ACCUM_THRESH -- requirements
Module: popcnt_accum_thresh

---
 rtl/popcnt_accum_thresh.sv | 115 +++++++++++
 tb/tb_popcnt_accum_thresh.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/popcnt_accum_thresh.sv
// Accumulates BEATS popcount beats per neuron and binarizes the sum.
// Define POPCNT_THRESH_EN to use the thr port; otherwise the threshold is (BEATS*LEN)/2.
module popcnt_accum_thresh #(
  parameter int LEN   = 450,
  parameter int BEATS = 4,
  parameter int CW    = $clog2(LEN),
  parameter int AW    = CW + $clog2(BEATS) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_cnt,
  input  logic [AW-1:0] thr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_acc,
  output logic          out_act,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam int BW = $clog2(BEATS + 1);
  localparam logic [BW-1:0] BEATS_C = BW'(BEATS);

  state_t        state, state_nx;
  logic [AW-1:0] acc, acc_nx;
  logic [BW-1:0] cnt, cnt_nx;
  logic [BW-1:0] cnt_inc;
  logic          err_nx;
  logic          take;
  logic          over;
  logic [AW-1:0] thr_eff;

`ifdef POPCNT_THRESH_EN
  logic [AW-1:0] thr_q, thr_nx;

  assign thr_eff = thr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) thr_q <= '0;
    else        thr_q <= thr_nx;
  end

  always_comb begin
    thr_nx = thr_q;
    if (take && state == IDLE) thr_nx = thr;
  end
`else
  localparam logic [AW-1:0] THR_C = AW'((BEATS * LEN) / 2);
  logic unused_thr;

  assign unused_thr = ^thr;
  assign thr_eff    = THR_C;
`endif

  assign in_ready  = (state != DONE);
  assign take      = in_valid && in_ready;
  assign cnt_inc   = cnt + BW'(1);
  assign over      = ({{(32-CW){1'b0}}, in_cnt} > LEN);
  assign out_valid = (state == DONE);
  assign out_acc   = acc;
  assign out_act   = (state == DONE) && (acc >= thr_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      err   <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    err_nx   = err | (take & over);
    unique case (state)
      IDLE: begin
        if (take) begin
          acc_nx   = AW'(in_cnt);
          cnt_nx   = BW'(1);
          state_nx = (BEATS == 1) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (take) begin
          acc_nx = acc + AW'(in_cnt);
          cnt_nx = cnt_inc;
          if (cnt_inc == BEATS_C) state_nx = DONE;
        end
      end
      DONE: begin
        // acc is left as-is so out_acc stays valid through the handshake
        if (out_ready) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_popcnt_accum_thresh.sv
// Directed bench for popcnt_accum_thresh: a 4-beat instance
// and a 1-beat instance, driven and sampled on the falling edge.
module tb_popcnt_accum_thresh;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_cnt;
  logic [11:0] thr;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_acc;
  logic        out_act;
  logic        err;

  logic        s_valid;
  logic        s_ready;
  logic [8:0]  s_cnt;
  logic [9:0]  s_thr;
  logic        s_ovalid;
  logic        s_oready;
  logic [9:0]  s_acc;
  logic        s_act;
  logic        s_err;

  int n_chk;
  int n_fail;

  popcnt_accum_thresh #(.LEN(450), .BEATS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cnt(in_cnt), .thr(thr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_act(out_act), .err(err)
  );

  popcnt_accum_thresh #(.LEN(450), .BEATS(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_valid), .in_ready(s_ready),
    .in_cnt(s_cnt), .thr(s_thr),
    .out_valid(s_ovalid), .out_ready(s_oready),
    .out_acc(s_acc), .out_act(s_act), .err(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int c0, c1, c2, c3;
    int t0, t1;
    bit gap;
    int eacc;
    bit eact;
    string name;
  } vec_t;

  vec_t v[6];

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic run_neuron(input vec_t x);
    int c[4];
    c[0] = x.c0; c[1] = x.c1; c[2] = x.c2; c[3] = x.c3;
    for (int i = 0; i < 4; i++) begin
      if (x.gap && i > 0) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_cnt   = 9'd511;
      end
      @(negedge clk);
      if (i == 3) chk({x.name, " early_valid"}, int'(out_valid), 0);
      chk({x.name, " ready"}, int'(in_ready), 1);
      in_valid = 1'b1;
      in_cnt   = 9'(c[i]);
      thr      = 12'((i == 0) ? x.t0 : x.t1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk({x.name, " valid"}, int'(out_valid), 1);
    chk({x.name, " acc"}, int'(out_acc), x.eacc);
    chk({x.name, " act"}, int'(out_act), int'(x.eact));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({x.name, " drop"}, int'(out_valid), 0);
  endtask

  initial begin
    vec_t t;
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_cnt = '0; thr = '0; out_ready = 1'b0;
    s_valid = 1'b0; s_cnt = '0; s_thr = '0; s_oready = 1'b0;

    v[0] = '{450, 450, 450, 450, 900, 900, 1'b0, 1800, 1'b1, "full"};
    v[1] = '{225, 225, 225, 224, 900, 900, 1'b0, 899, 1'b0, "below"};
    v[2] = '{225, 225, 225, 225, 900, 900, 1'b0, 900, 1'b1, "equal"};
    v[3] = '{250, 250, 250, 250, 1000, 0, 1'b0, 1000, 1'b1, "thr1000"};
`ifdef POPCNT_THRESH_EN
    v[4] = '{250, 250, 250, 250, 1001, 0, 1'b0, 1000, 1'b0, "thr1001"};
`else
    v[4] = '{250, 250, 250, 250, 1001, 0, 1'b0, 1000, 1'b1, "thr1001"};
`endif
    v[5] = '{100, 200, 300, 400, 900, 900, 1'b1, 1000, 1'b1, "gaps"};

    @(negedge clk);
    @(negedge clk);
    chk("rst valid", int'(out_valid), 0);
    chk("rst acc", int'(out_acc), 0);
    chk("rst act", int'(out_act), 0);
    chk("rst err", int'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst ready", int'(in_ready), 1);

    foreach (v[i]) run_neuron(v[i]);

    // Backpressure: result held while a beat waits.
    t = '{10, 10, 10, 10, 900, 900, 1'b0, 40, 1'b0, "bp"};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_cnt = 9'd10;
    end
    @(negedge clk);
    in_cnt = 9'd7;
    for (int k = 0; k < 5; k++) begin
      chk("bp ready", int'(in_ready), 0);
      chk("bp acc", int'(out_acc), 40);
      chk("bp valid", int'(out_valid), 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp idle valid", int'(out_valid), 0);
    chk("bp idle ready", int'(in_ready), 1);
    chk("bp no take", int'(out_acc), 40);
    @(negedge clk);
    chk("bp first", int'(out_acc), 7);
    for (int i = 0; i < 3; i++) @(negedge clk);
    in_valid = 1'b0;
    chk("bp next acc", int'(out_acc), 28);
    chk("bp next valid", int'(out_valid), 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of a neuron.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_cnt = 9'd10;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid rst acc", int'(out_acc), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mid rst valid", int'(out_valid), 0);
    end
    run_neuron(t);

    // Out-of-range beat sets err and is still summed.
    chk("err pre", int'(err), 0);
    t = '{460, 0, 0, 0, 900, 900, 1'b0, 460, 1'b0, "err"};
    run_neuron(t);
    chk("err set", int'(err), 1);
    t = '{1, 2, 3, 4, 900, 900, 1'b0, 10, 1'b0, "sticky"};
    run_neuron(t);
    chk("err sticky", int'(err), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("err clear", int'(err), 0);
    rst_n = 1'b1;

    // Single-beat instance.
    @(negedge clk);
    chk("b1 idle", int'(s_ovalid), 0);
    s_valid = 1'b1; s_cnt = 9'd300; s_thr = 10'd225;
    @(negedge clk);
    s_valid = 1'b0; s_thr = 10'd0;
    chk("b1 valid", int'(s_ovalid), 1);
    chk("b1 acc", int'(s_acc), 300);
    chk("b1 act", int'(s_act), 1);
    chk("b1 ready", int'(s_ready), 0);
    s_oready = 1'b1;
    @(negedge clk);
    s_oready = 1'b0;
    chk("b1 drop", int'(s_ovalid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
